// File: rtl/script_fetcher.sv
// script_fetcher: streams 32-bit script words from a registered-read ROM into a
// valid/ready instruction stream, stopping after the END word. A small skid FIFO
// absorbs the one-cycle ROM latency against downstream backpressure.
module script_fetcher #(
   parameter int unsigned DEPTH      = 2,
   parameter logic [3:0]  END_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        call_valid,
   output logic        call_ready,
   input  logic [8:0]  call_addr,
   input  logic        abort,
   output logic [8:0]  rom_addr,
   input  logic [31:0] rom_instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic        instr_last,
   output logic        busy
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e         state;
   logic [8:0]     pc;
   logic           inflight;
   logic           discard;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_next;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [31:0]    mem_data [DEPTH];
   logic           mem_last [DEPTH];

   logic           pop;
   logic           push;
   logic           is_end;
   logic           ret_end;
   logic           issue;
   logic           accept;
   logic [31:0]    occ;
   logic           unused_addr;

   // Low address bits are ignored; the start address is always word aligned.
   assign unused_addr = ^call_addr[1:0];

   // Handshakes, issue decision and FIFO occupancy bookkeeping.
   always_comb begin
      pop        = instr_valid && instr_ready;
      push       = inflight && !discard;
      is_end     = (rom_instr[31:28] == END_OPCODE);
      ret_end    = push && is_end;
      // Occupancy after this cycle, counting the read still in flight.
      occ        = 32'(count) + 32'(inflight) - 32'(pop);
      issue      = (state == StFetch) && !abort && (occ < DEPTH);
      accept     = call_valid && call_ready && !abort;
      count_next = count + CW'(push) - CW'(pop);
   end

   // Status outputs follow the state register; rom_addr always presents pc.
   always_comb begin
      call_ready  = (state == StIdle);
      busy        = (state != StIdle);
      rom_addr    = pc;
      instr_valid = (count != '0);
      instr_data  = instr_valid ? mem_data[rd_ptr] : '0;
      instr_last  = instr_valid ? mem_last[rd_ptr] : 1'b0;
   end

   // Sequencer FSM with read tracking and FIFO pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         pc       <= '0;
         inflight <= 1'b0;
         discard  <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (abort) begin
         state    <= StIdle;
         inflight <= 1'b0;
         discard  <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         // A read issued alongside the END return is speculative; drop its data.
         discard  <= issue && ret_end;
         if (issue) begin
            pc <= pc + 9'd4;
         end
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         count <= count_next;
         unique case (state)
            StIdle: begin
               if (accept) begin
                  state <= StFetch;
                  pc    <= {call_addr[8:2], 2'b00};
               end
            end
            StFetch: begin
               if (ret_end) begin
                  state <= StDrain;
               end
            end
            StDrain: begin
               // No issues happen here, so an empty FIFO means nothing is pending.
               if (count_next == '0) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // FIFO storage; contents are only visible while count is nonzero.
   always_ff @(posedge clk) begin
      if (push && !abort) begin
         mem_data[wr_ptr] <= rom_instr;
         mem_last[wr_ptr] <= is_end;
      end
   end

endmodule

// File: tb/tb_script_fetcher.sv
// Directed testbench for script_fetcher with a registered-read ROM model.
module tb_script_fetcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        call_valid;
   logic        call_ready;
   logic [8:0]  call_addr;
   logic        abort;
   logic [8:0]  rom_addr;
   logic [31:0] rom_instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic        instr_last;
   logic        busy;

   logic [31:0] rom [128];

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] cap_data [$];
   logic        cap_last [$];
   int          cap_cyc  [$];
   int          idle_cyc;
   int          stall_breaks;
   int          max_cnt;
   logic [8:0]  first_rom_addr;

   always #5 clk = ~clk;

   script_fetcher #(
      .DEPTH      (2),
      .END_OPCODE (4'hF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .call_valid  (call_valid),
      .call_ready  (call_ready),
      .call_addr   (call_addr),
      .abort       (abort),
      .rom_addr    (rom_addr),
      .rom_instr   (rom_instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_data  (instr_data),
      .instr_last  (instr_last),
      .busy        (busy)
   );

   // ROM with one-cycle registered read.
   always @(posedge clk) rom_instr <= rom[rom_addr[8:2]];

   task automatic rom_fill();
      for (int i = 0; i < 128; i++) rom[i] = 32'h1111_0000 | 32'(i);
   endtask

   task automatic load_basic();
      rom_fill();
      rom[4] = 32'hA000_0001;
      rom[5] = 32'hA000_0002;
      rom[6] = 32'hA000_0003;
      rom[7] = 32'hF000_0000;
   endtask

   // Issue a call and record every popped word for a fixed number of cycles.
   // Cycle 0 is the sample point just after the accepting edge.
   task automatic stream(input logic [8:0] addr, input logic [15:0] rpat, input int ncyc);
      logic        prev_stall;
      logic [31:0] prev_data;
      cap_data.delete();
      cap_last.delete();
      cap_cyc.delete();
      idle_cyc     = -1;
      stall_breaks = 0;
      max_cnt      = 0;
      prev_stall   = 1'b0;
      prev_data    = '0;
      call_valid   = 1'b1;
      call_addr    = addr;
      @(posedge clk); #1;
      call_valid     = 1'b0;
      first_rom_addr = rom_addr;
      for (int c = 0; c < ncyc; c++) begin
         instr_ready = rpat[c % 16];
         if (prev_stall && (instr_data !== prev_data)) stall_breaks++;
         if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
         if (instr_valid && instr_ready) begin
            cap_data.push_back(instr_data);
            cap_last.push_back(instr_last);
            cap_cyc.push_back(c);
         end
         if (call_ready && idle_cyc < 0) idle_cyc = c;
         prev_stall = instr_valid && !instr_ready;
         prev_data  = instr_data;
         @(posedge clk); #1;
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (call_ready !== 1'b1) begin miscompares++;
         $display("FAIL reset_call_ready: got %0h want 1", call_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++;
         $display("FAIL reset_busy: got %0h want 0", busy); end
      vectors++; if (instr_valid !== 1'b0) begin miscompares++;
         $display("FAIL reset_instr_valid: got %0h want 0", instr_valid); end
      vectors++; if (instr_last !== 1'b0) begin miscompares++;
         $display("FAIL reset_instr_last: got %0h want 0", instr_last); end
      vectors++; if (instr_data !== 32'h0) begin miscompares++;
         $display("FAIL reset_instr_data: got %h want 0", instr_data); end
      vectors++; if (rom_addr !== 9'h000) begin miscompares++;
         $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'hA000_0001; exp_w[1] = 32'hA000_0002;
      exp_w[2] = 32'hA000_0003; exp_w[3] = 32'hF000_0000;
      load_basic();
      stream(9'h010, 16'hFFFF, 20);
      vectors++; if (cap_data.size() !== 4) begin miscompares++;
         $display("FAIL basic_count: got %0d want 4", cap_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < cap_data.size()) begin
            vectors++; if (cap_data[i] !== exp_w[i]) begin miscompares++;
               $display("FAIL basic_data[%0d]: got %h want %h", i, cap_data[i], exp_w[i]); end
            vectors++; if (cap_last[i] !== (i == 3)) begin miscompares++;
               $display("FAIL basic_last[%0d]: got %0h want %0h", i, cap_last[i], (i == 3)); end
            vectors++; if (cap_cyc[i] !== 2 + i) begin miscompares++;
               $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, cap_cyc[i], 2 + i); end
         end
      end
      vectors++; if (idle_cyc !== 6) begin miscompares++;
         $display("FAIL basic_call_ready_cycle: got %0d want 6", idle_cyc); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'hA000_0001; exp_w[1] = 32'hA000_0002;
      exp_w[2] = 32'hA000_0003; exp_w[3] = 32'hF000_0000;
      load_basic();
      // ready per cycle: 1,0,0,1,0,1,0,0,1,0,1,1,...
      stream(9'h010, 16'hFD29, 40);
      vectors++; if (cap_data.size() !== 4) begin miscompares++;
         $display("FAIL bp_count: got %0d want 4", cap_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < cap_data.size()) begin
            vectors++; if (cap_data[i] !== exp_w[i]) begin miscompares++;
               $display("FAIL bp_data[%0d]: got %h want %h", i, cap_data[i], exp_w[i]); end
            vectors++; if (cap_last[i] !== (i == 3)) begin miscompares++;
               $display("FAIL bp_last[%0d]: got %0h want %0h", i, cap_last[i], (i == 3)); end
         end
      end
      vectors++; if (stall_breaks !== 0) begin miscompares++;
         $display("FAIL bp_stable: got %0d changes want 0", stall_breaks); end
      vectors++; if ((max_cnt <= 2) !== 1'b1) begin miscompares++;
         $display("FAIL bp_max_count: got %0d want <=2", max_cnt); end
      vectors++; if ((idle_cyc >= 0) !== 1'b1) begin miscompares++;
         $display("FAIL bp_idle: got %0d want >=0", idle_cyc); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_w [4];
      rom_fill();
      rom[126] = 32'hB000_01F8;
      rom[127] = 32'hB000_01FC;
      rom[0]   = 32'hB000_0000;
      rom[1]   = 32'hF000_0004;
      exp_w[0] = 32'hB000_01F8; exp_w[1] = 32'hB000_01FC;
      exp_w[2] = 32'hB000_0000; exp_w[3] = 32'hF000_0004;
      stream(9'h1F8, 16'hFFFF, 20);
      vectors++; if (first_rom_addr !== 9'h1F8) begin miscompares++;
         $display("FAIL wrap_rom_addr: got %h want 1f8", first_rom_addr); end
      vectors++; if (cap_data.size() !== 4) begin miscompares++;
         $display("FAIL wrap_count: got %0d want 4", cap_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < cap_data.size()) begin
            vectors++; if (cap_data[i] !== exp_w[i]) begin miscompares++;
               $display("FAIL wrap_data[%0d]: got %h want %h", i, cap_data[i], exp_w[i]); end
            vectors++; if (cap_last[i] !== (i == 3)) begin miscompares++;
               $display("FAIL wrap_last[%0d]: got %0h want %0h", i, cap_last[i], (i == 3)); end
         end
      end
   endtask

   task automatic test_immediate_end();
      rom_fill();
      rom[4] = 32'hF000_00AA;
      stream(9'h013, 16'hFFFF, 12);
      vectors++; if (first_rom_addr !== 9'h010) begin miscompares++;
         $display("FAIL imm_rom_addr: got %h want 010", first_rom_addr); end
      vectors++; if (cap_data.size() !== 1) begin miscompares++;
         $display("FAIL imm_count: got %0d want 1", cap_data.size()); end
      if (cap_data.size() > 0) begin
         vectors++; if (cap_data[0] !== 32'hF000_00AA) begin miscompares++;
            $display("FAIL imm_data: got %h want f00000aa", cap_data[0]); end
         vectors++; if (cap_last[0] !== 1'b1) begin miscompares++;
            $display("FAIL imm_last: got %0h want 1", cap_last[0]); end
         vectors++; if (cap_cyc[0] !== 2) begin miscompares++;
            $display("FAIL imm_cycle: got %0d want 2", cap_cyc[0]); end
      end
      vectors++; if (idle_cyc !== 3) begin miscompares++;
         $display("FAIL imm_call_ready_cycle: got %0d want 3", idle_cyc); end
      vectors++; if (busy !== 1'b0) begin miscompares++;
         $display("FAIL imm_busy: got %0h want 0", busy); end
   endtask

   task automatic test_abort();
      rom_fill();
      for (int i = 0; i < 9; i++) rom[16 + i] = 32'hC000_0000 + 32'(i);
      rom[25] = 32'hF000_0009;
      instr_ready = 1'b0;
      call_valid  = 1'b1;
      call_addr   = 9'h040;
      @(posedge clk); #1;
      call_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      vectors++; if (instr_data !== 32'hC000_0000) begin miscompares++;
         $display("FAIL abort_stall_head: got %h want c0000000", instr_data); end
      vectors++; if (rom_addr !== 9'h048) begin miscompares++;
         $display("FAIL abort_issue_stop: got %h want 048", rom_addr); end
      // Abort together with a competing call: the call must be ignored.
      abort      = 1'b1;
      call_valid = 1'b1;
      call_addr  = 9'h010;
      @(posedge clk); #1;
      abort      = 1'b0;
      call_valid = 1'b0;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++;
         $display("FAIL abort_valid: got %0h want 0", instr_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++;
         $display("FAIL abort_busy: got %0h want 0", busy); end
      @(posedge clk); #1;
      vectors++; if ({busy, instr_valid} !== 2'b00) begin miscompares++;
         $display("FAIL abort_settle: got %b want 00", {busy, instr_valid}); end
      load_basic();
      stream(9'h010, 16'hFFFF, 20);
      vectors++; if (cap_data.size() !== 4) begin miscompares++;
         $display("FAIL abort_recall_count: got %0d want 4", cap_data.size()); end
      if (cap_data.size() > 0) begin
         vectors++; if (cap_data[0] !== 32'hA000_0001) begin miscompares++;
            $display("FAIL abort_recall_first: got %h want a0000001", cap_data[0]); end
         vectors++; if (cap_cyc[0] !== 2) begin miscompares++;
            $display("FAIL abort_recall_cycle: got %0d want 2", cap_cyc[0]); end
      end
   endtask

   task automatic test_async_reset();
      int seen;
      load_basic();
      instr_ready = 1'b1;
      call_valid  = 1'b1;
      call_addr   = 9'h010;
      @(posedge clk); #1;
      call_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if ({instr_valid, instr_last, busy, call_ready} !== 4'b0001) begin
         miscompares++;
         $display("FAIL areset_flags: got %b want 0001",
                  {instr_valid, instr_last, busy, call_ready}); end
      vectors++; if (instr_data !== 32'h0) begin miscompares++;
         $display("FAIL areset_data: got %h want 0", instr_data); end
      vectors++; if (rom_addr !== 9'h000) begin miscompares++;
         $display("FAIL areset_rom_addr: got %h want 000", rom_addr); end
      #3 rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (instr_valid) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++;
         $display("FAIL areset_no_valid: got %0d cycles want 0", seen); end
      stream(9'h010, 16'hFFFF, 20);
      vectors++; if (cap_data.size() !== 4) begin miscompares++;
         $display("FAIL areset_recall_count: got %0d want 4", cap_data.size()); end
      if (cap_data.size() == 4) begin
         vectors++; if (cap_data[3] !== 32'hF000_0000) begin miscompares++;
            $display("FAIL areset_recall_last: got %h want f0000000", cap_data[3]); end
      end
   endtask

   initial begin
      call_valid  = 1'b0;
      call_addr   = '0;
      abort       = 1'b0;
      instr_ready = 1'b0;
      rom_fill();
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_immediate_end();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
